// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Registers the EXE->MEM bus,
//            performs at most one data-memory load/store per instruction
//            over a req/ack handshake, aligns/extends load data and
//            presents a registered MEM->WB bus under valid/ready.
//            Non-memory instructions pass through with one cycle latency.
// Ports    : clk, resetn (async active-low)
//            EXE_MEM_BUS[109:0] {through[15:0], alu_data, out_data, pc[29:0]}
//            in_valid / in_ready      upstream handshake
//            MEM_WB_BUS[72:0] {spare[4:0], wb_en, wb_reg[4:0], result, pc}
//            out_valid / out_ready    downstream handshake
//            dm_req/dm_we/dm_addr/dm_be/dm_wdata/dm_rdata/dm_ack  data memory
//            adel/ades (one-cycle fault pulses), badvaddr (faulting address)
// Revision : 1.0  initial release
// ============================================================================
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic [109:0] EXE_MEM_BUS,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [72:0]  MEM_WB_BUS,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         dm_req,
  output logic         dm_we,
  output logic [29:0]  dm_addr,
  output logic [3:0]   dm_be,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  input  logic         dm_ack,
  output logic         adel,
  output logic         ades,
  output logic [31:0]  badvaddr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Incoming bus fields
  logic [15:0] in_through;
  logic [31:0] in_alu;
  logic [31:0] in_data;
  logic [29:0] in_pc;
  assign in_through = EXE_MEM_BUS[109:94];
  assign in_alu     = EXE_MEM_BUS[93:62];
  assign in_data    = EXE_MEM_BUS[61:30];
  assign in_pc      = EXE_MEM_BUS[29:0];

  logic       in_mem_en, in_we;
  logic [1:0] in_size;
  assign in_mem_en = in_through[15];
  assign in_we     = in_through[14];
  assign in_size   = in_through[13:12];

  logic in_aligned;
  always_comb begin
    in_aligned = 1'b1;
    case (in_size)
      2'b00:   in_aligned = 1'b1;
      2'b01:   in_aligned = ~in_alu[0];
      default: in_aligned = (in_alu[1:0] == 2'b00);
    endcase
  end

  // Store lane placement for the incoming instruction
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = in_data;
    case (in_size)
      2'b00: begin
        st_be    = 4'b0001 << in_alu[1:0];
        st_wdata = {4{in_data[7:0]}};
      end
      2'b01: begin
        st_be    = in_alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_data;
      end
    endcase
  end

  // Handshake and event decode
  logic accept, take_alu, take_mem, take_fault, complete;
  assign in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign take_alu   = accept & ~in_mem_en;
  assign take_mem   = accept &  in_mem_en &  in_aligned;
  assign take_fault = accept &  in_mem_en & ~in_aligned;
  assign complete   = (state == REQ) & dm_ack;

  assign dm_req    = (state == REQ);
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      REQ:     if (dm_ack) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A new instruction overrides the default transition; a misaligned
    // access is dropped and leaves the stage empty.
    if (accept) begin
      if (!in_mem_en)     state_nxt = DONE;
      else if (in_aligned) state_nxt = REQ;
      else                state_nxt = IDLE;
    end
  end

  // Instruction held while the memory access is outstanding
  logic        we_q, uns_q, wb_en_q;
  logic [1:0]  size_q, alo_q;
  logic [4:0]  wb_reg_q, spare_q;
  logic [29:0] pc_q;
  logic [31:0] data_q;

  // Load alignment and extension
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result, result;
  always_comb begin
    ld_byte = dm_rdata[7:0];
    case (alo_q)
      2'd0: ld_byte = dm_rdata[7:0];
      2'd1: ld_byte = dm_rdata[15:8];
      2'd2: ld_byte = dm_rdata[23:16];
      2'd3: ld_byte = dm_rdata[31:24];
      default: ld_byte = dm_rdata[7:0];
    endcase
    ld_half = alo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      2'b00:   ld_result = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_result = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_result = dm_rdata;
    endcase
    result = we_q ? data_q : ld_result;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MEM_WB_BUS <= '0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_be      <= '0;
      dm_wdata   <= '0;
      adel       <= 1'b0;
      ades       <= 1'b0;
      badvaddr   <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wb_en_q    <= 1'b0;
      size_q     <= '0;
      alo_q      <= '0;
      wb_reg_q   <= '0;
      spare_q    <= '0;
      pc_q       <= '0;
      data_q     <= '0;
    end else begin
      adel <= 1'b0;
      ades <= 1'b0;
      if (take_alu)
        MEM_WB_BUS <= {in_through[4:0], in_through[10], in_through[9:5], in_data, in_pc};
      if (take_mem) begin
        we_q     <= in_we;
        uns_q    <= in_through[11];
        wb_en_q  <= in_through[10];
        size_q   <= in_size;
        alo_q    <= in_alu[1:0];
        wb_reg_q <= in_through[9:5];
        spare_q  <= in_through[4:0];
        pc_q     <= in_pc;
        data_q   <= in_data;
        dm_we    <= in_we;
        dm_addr  <= in_alu[31:2];
        dm_be    <= in_we ? st_be : 4'b1111;
        dm_wdata <= st_wdata;
      end
      if (take_fault) begin
        adel     <= ~in_we;
        ades     <=  in_we;
        badvaddr <= in_alu;
      end
      if (complete)
        MEM_WB_BUS <= {spare_q, wb_en_q, wb_reg_q, result, pc_q};
    end
  end

endmodule
`default_nettype wire
